// File: rtl/lc2k_mem_requester.sv
// lc2k_mem_requester: one-at-a-time lw/sw requester driving a req/ack word-addressed memory port.
module lc2k_mem_requester #(
    parameter int ADDR_BITS = 6,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_valid,
    input  logic                 cpu_write,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    output logic                 cpu_ready,
    output logic                 resp_valid,
    output logic [31:0]          resp_data,
    output logic                 addr_error,
    output logic                 timeout_error,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic                 mem_ack,
    input  logic [31:0]          mem_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          out_of_range;

    assign cpu_ready = (state == IDLE);
    assign out_of_range = (cpu_addr >> ADDR_BITS) != 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            addr_error    <= 1'b0;
            timeout_error <= 1'b0;
        end else begin
            resp_valid    <= 1'b0;
            addr_error    <= 1'b0;
            timeout_error <= 1'b0;
            case (state)
                IDLE: if (cpu_valid) begin
                    if (out_of_range) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        addr_error <= 1'b1;
                        resp_data  <= '0;
                    end else begin
                        state     <= ISSUE;
                        mem_req   <= 1'b1;
                        mem_we    <= cpu_write;
                        mem_addr  <= cpu_addr[ADDR_BITS-1:0];
                        mem_wdata <= cpu_wdata;
                        cnt       <= '0;
                    end
                end
                ISSUE: begin
                    // ack wins over a timeout firing on the same edge
                    if (mem_ack) begin
                        state      <= RESP;
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_data  <= mem_we ? 32'd0 : mem_rdata;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state         <= RESP;
                        mem_req       <= 1'b0;
                        resp_valid    <= 1'b1;
                        timeout_error <= 1'b1;
                        resp_data     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lc2k_mem_requester.sv
// tb_lc2k_mem_requester: directed stimulus, bench memory responder, scoreboarded responses.
module tb_lc2k_mem_requester;
    logic        clk = 0, reset = 1;
    logic        cpu_valid = 0, cpu_write = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0;
    logic        cpu_ready, resp_valid, addr_error, timeout_error;
    logic [31:0] resp_data;
    logic        mem_req, mem_we, mem_ack = 0;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata = 0;

    lc2k_mem_requester #(.ADDR_BITS(6), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .cpu_valid(cpu_valid), .cpu_write(cpu_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .addr_error(addr_error),
        .timeout_error(timeout_error), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] d; logic ae; logic te;} resp_t;
    resp_t q[$];
    int    checks = 0, failures = 0;
    int    cyc = 0;
    int    acc_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: acks on req cycle ack_delay+1 (never if negative)
    logic [31:0] mem [64];
    int          wait_cnt = 0, last_len = 0, total_req = 0, ack_delay = 0;
    bit          spurious = 0;
    logic        s_we;
    logic [5:0]  s_addr;
    logic [31:0] s_wdata;
    always @(negedge clk) begin
        if (mem_req) begin
            wait_cnt++;
            total_req++;
            if (wait_cnt == 1) begin
                s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
            end else
                check("req_stable", {25'd0, mem_we, mem_addr, mem_wdata}, {25'd0, s_we, s_addr, s_wdata});
            mem_ack = ack_delay >= 0 && wait_cnt == ack_delay + 1;
            mem_rdata = mem_we ? 32'hBAD0BAD0 : mem[mem_addr];
            if (mem_ack && mem_we) mem[mem_addr] = mem_wdata;
        end else begin
            if (wait_cnt > 0) last_len = wait_cnt;
            wait_cnt = 0;
            mem_ack = spurious;
            mem_rdata = 32'hDEADBEEF;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (cpu_valid && cpu_ready) acc_q.push_back(cyc);
            if (resp_valid) begin
                if (q.size() == 0) check("unexpected_resp", {63'd0, resp_valid}, 64'd0);
                else begin
                    resp_t e;
                    e = q.pop_front();
                    check("resp_data", {32'd0, resp_data}, {32'd0, e.d});
                    check("addr_error", {63'd0, addr_error}, {63'd0, e.ae});
                    check("timeout_error", {63'd0, timeout_error}, {63'd0, e.te});
                end
            end else
                check("err_flags_idle", {62'd0, addr_error, timeout_error}, 64'd0);
        end
    end

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input bit push, input resp_t e, input bit hold);
        int n = 0;
        if (push) q.push_back(e);
        cpu_valid = 1; cpu_write = w; cpu_addr = a; cpu_wdata = d;
        while (!cpu_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            failures++;
            $display("FAIL accept_wait cpu_ready=%0b after %0d cycles", cpu_ready, n);
        end
        @(posedge clk); #1;
        if (!hold) cpu_valid = 0;
    endtask

    // Returns cycles from accept until resp_valid seen; checks one-cycle pulse and ready return
    task automatic wait_resp(input string name, input int exp_lat);
        int n = 0;
        do begin @(negedge clk); n++; end while (!resp_valid && n < 100);
        check({name, "_latency"}, n, exp_lat);
        @(negedge clk);
        check({name, "_pulse_end"}, {63'd0, resp_valid}, 64'd0);
        check({name, "_ready_back"}, {63'd0, cpu_ready}, 64'd1);
    endtask

    initial begin
        int tr;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + i;
        mem[14] = 32'd2;
        mem[15] = 32'h0F0F;
        repeat (2) @(negedge clk);
        check("rst_mem_req", {63'd0, mem_req}, 0);
        check("rst_mem_we", {63'd0, mem_we}, 0);
        check("rst_resp_valid", {63'd0, resp_valid}, 0);
        check("rst_errs", {62'd0, addr_error, timeout_error}, 0);
        check("rst_resp_data", {32'd0, resp_data}, 0);
        check("rst_mem_addr", {58'd0, mem_addr}, 0);
        check("rst_mem_wdata", {32'd0, mem_wdata}, 0);
        check("rst_cpu_ready", {63'd0, cpu_ready}, 1);
        reset = 0;

        // Reset in the middle of an outstanding load
        ack_delay = -1;
        send(0, 12, 0, 0, '0, 0);
        repeat (3) @(negedge clk);
        check("midrst_req_before", {63'd0, mem_req}, 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("midrst_req_dropped", {63'd0, mem_req}, 0);
        check("midrst_ready", {63'd0, cpu_ready}, 1);
        repeat (5) @(negedge clk);

        // Store with immediate ack, then load it back
        ack_delay = 0;
        send(1, 13, 5, 1, '{d: 0, ae: 0, te: 0}, 0);
        wait_resp("sw13", 2);
        check("sw13_len", last_len, 1);
        check("sw13_fields", {25'd0, s_we, s_addr, s_wdata}, {25'd0, 1'b1, 6'd13, 32'd5});
        send(0, 13, 0, 1, '{d: 5, ae: 0, te: 0}, 0);
        wait_resp("lw13", 2);

        // Load with 4 wait cycles
        ack_delay = 4;
        send(0, 14, 0, 1, '{d: 2, ae: 0, te: 0}, 0);
        wait_resp("lw14", 6);
        check("lw14_len", last_len, 5);
        check("lw14_addr", {58'd0, s_addr}, 14);
        repeat (3) @(negedge clk);
        check("resp_data_hold", {32'd0, resp_data}, 2);

        // Out-of-range addresses never reach memory
        tr = total_req;
        send(0, 64, 0, 1, '{d: 0, ae: 1, te: 0}, 0);
        wait_resp("lw64", 1);
        send(0, 32'hFFFFFFFF, 0, 1, '{d: 0, ae: 1, te: 0}, 0);
        wait_resp("lwFFFF", 1);
        check("addr_err_no_req", total_req, tr);

        // Timeout, then ack on the last allowed cycle
        ack_delay = -1;
        send(0, 15, 0, 1, '{d: 0, ae: 0, te: 1}, 0);
        wait_resp("timeout", 16);
        check("timeout_len", last_len, 15);
        ack_delay = 14;
        send(0, 15, 0, 1, '{d: 32'h0F0F, ae: 0, te: 0}, 0);
        wait_resp("ack_last", 16);
        check("ack_last_len", last_len, 15);

        // Spurious ack while idle, then back-to-back requests
        spurious = 1;
        tr = total_req;
        repeat (4) @(negedge clk);
        check("spurious_no_req", total_req, tr);
        check("spurious_ready", {63'd0, cpu_ready}, 1);
        ack_delay = 0;
        acc_q.delete();
        send(1, 20, 32'hCAFE, 1, '{d: 0, ae: 0, te: 0}, 1);
        send(0, 20, 0, 1, '{d: 32'hCAFE, ae: 0, te: 0}, 1);
        send(0, 13, 0, 1, '{d: 5, ae: 0, te: 0}, 0);
        spurious = 0;
        repeat (6) @(negedge clk);
        check("b2b_accepts", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            check("b2b_gap1", acc_q[1] - acc_q[0], 3);
            check("b2b_gap2", acc_q[2] - acc_q[1], 3);
        end
        check("sb_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule

// File: doc/lc2k_mem_requester.md
Name: lc2k_mem_requester

Overview:
- Initiator side of the LC2K data-memory interface; used by the multicycle/pipelined core in place of direct combinational memory access.
- Accepts one lw/sw request at a time from the core's MEM stage and drives a req/ack word-addressed memory port.
- Returns load data or store completion to the core, checks addresses against the memory depth, and bounds every access with a timeout.

Parameters:
ADDR_BITS, 6, word-address width of the memory port (depth = 2**ADDR_BITS = 64 words)
TIMEOUT, 15, max cycles mem_req is held without mem_ack before abort (1..255)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
cpu_valid  in  1  core presents a request this cycle
cpu_write  in  1  1 = sw, 0 = lw
cpu_addr  in  32  word address (ALU result)
cpu_wdata  in  32  store data (regB value)
cpu_ready  out  1  requester can accept; high only in IDLE
resp_valid  out  1  one-cycle pulse: access finished (ok or error)
resp_data  out  32  load data, valid with resp_valid; 0 for stores and errors
addr_error  out  1  one-cycle pulse with resp_valid: cpu_addr >= 2**ADDR_BITS
timeout_error  out  1  one-cycle pulse with resp_valid: no mem_ack within TIMEOUT
mem_req  out  1  request to memory, held until mem_ack
mem_we  out  1  1 = write
mem_addr  out  ADDR_BITS  word address
mem_wdata  out  32  write data
mem_ack  in  1  memory completes current request this cycle
mem_rdata  in  32  read data, valid when mem_ack and !mem_we

Behaviour:
- Reset: state IDLE; mem_req, mem_we, resp_valid, addr_error, timeout_error = 0; resp_data, mem_addr, mem_wdata, timeout counter = 0. A reset during ISSUE drops mem_req at that edge. No response is produced for the aborted access.
- cpu_ready = (state == IDLE), combinational from state. A request is accepted on an edge where cpu_valid && cpu_ready.
- States:
  - IDLE -> ISSUE on accept with in-range address. Latch cpu_write into mem_we, cpu_addr[ADDR_BITS-1:0] into mem_addr, cpu_wdata into mem_wdata. Assert mem_req. Clear the counter.
  - IDLE -> RESP on accept with out-of-range address (any bit above ADDR_BITS-1 set). No mem_req is issued. Set addr_error, resp_data = 0.
  - ISSUE -> RESP on a cycle with mem_ack = 1. Drop mem_req at that edge. resp_data = mem_rdata for loads, 0 for stores.
  - ISSUE with mem_ack = 0: counter increments. When the counter reaches TIMEOUT-1 without ack, go to RESP, drop mem_req, set timeout_error, resp_data = 0.
  - RESP -> IDLE unconditionally. resp_valid, and the applicable error flag, are high for exactly this one cycle.
- Latency: accept at edge N. mem_req high in cycle N+1. If ack is sampled at edge M, resp_valid is high in cycle M+1 and cpu_ready is high again in cycle M+2. Back-to-back zero-wait throughput is one access per 3 cycles.
- mem_addr, mem_we, and mem_wdata are stable for the whole time mem_req is high. Memory may ack in the first req cycle (minimum 1-cycle ack).
- mem_ack while not in ISSUE is ignored. mem_ack on the same edge the timeout fires counts as success: ack has priority over timeout.
- cpu_valid while cpu_ready = 0 is ignored; the core must hold the request.
- resp_data holds its value after the pulse until the next response.
- Counter width is ceil(log2(TIMEOUT+1)) bits; it never wraps.

Test Plan:
- Reset mid-ISSUE (lw addr 12, no ack), reset high one edge -> next cycle mem_req=0, cpu_ready=1, resp_valid never pulses.
- sw addr 13 data 5, mem_ack on first req cycle -> mem_req 1 cycle with we=1, addr=13, wdata=5; resp_valid pulse, resp_data=0, errors 0; then lw 13 with mem_rdata=5 -> resp_data=5.
- lw addr 14, mem_ack delayed 4 cycles -> mem_req high 5 cycles with addr=14 stable; resp_valid one cycle after ack; resp_data=mem_rdata=2.
- lw addr 64 (and addr 0xFFFFFFFF) -> mem_req never asserted; resp_valid+addr_error pulse at cycle N+1; resp_data=0.
- lw addr 15 with mem_ack held 0 -> mem_req high exactly 15 cycles; then resp_valid+timeout_error pulse; cpu_ready back next cycle. Repeat with ack on the 15th cycle -> success, no timeout_error.
- cpu_valid held continuously with 3 requests, 1-cycle ack, plus a spurious mem_ack in IDLE -> one accept per 3 cycles, spurious ack has no effect, 3 resp_valid pulses in order.
